// File: rtl/uart_mem_cmd_ctrl_if.sv
// Memory-access bus between the UART debug command controller (master) and the
// instruction/data memories (slave). Responses are 42 bits: {1'b1, addr[8:0], data[31:0]}.
interface uart_mem_cmd_ctrl_if;
    logic        write_mem_req;
    logic        target_mem_type;
    logic [8:0]  target_addr;
    logic        rw_flag;
    logic [31:0] wr_data;
    logic [41:0] imem_resp_data;
    logic        imem_resp_ready;
    logic [41:0] dmem_resp_data;
    logic        dmem_resp_ready;

    modport master (
        output write_mem_req, target_mem_type, target_addr, rw_flag, wr_data,
        input  imem_resp_data, imem_resp_ready, dmem_resp_data, dmem_resp_ready
    );

    modport slave (
        input  write_mem_req, target_mem_type, target_addr, rw_flag, wr_data,
        output imem_resp_data, imem_resp_ready, dmem_resp_data, dmem_resp_ready
    );
endinterface

// File: rtl/uart_mem_cmd_ctrl.sv
// UART debug memory-access initiator: parses command frames from the UART
// receiver, issues one-cycle memory requests while the CPU is halted and
// streams the ACK/NAK or 6-byte read reply back to the UART transmitter.
// Optional feature: define UART_CMD_CHKSUM_EN to require a trailing XOR
// checksum byte on every frame (checked in S_CHK before the request).
module uart_mem_cmd_ctrl #(
    parameter int unsigned RESP_TIMEOUT = 64,
    parameter logic [7:0]  ACK_BYTE     = 8'hA5,
    parameter logic [7:0]  NAK_BYTE     = 8'hEE
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [7:0]          rx_byte,
    input  logic                rx_valid,
    input  logic                cpu_enable,
    uart_mem_cmd_ctrl_if.master mem,
    output logic [7:0]          tx_byte,
    output logic                tx_valid,
    input  logic                tx_ready,
    output logic                busy
);
    localparam int unsigned TW = $clog2(RESP_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_HDR,
        S_ADDR,
        S_DATA,
`ifdef UART_CMD_CHKSUM_EN
        S_CHK,
`endif
        S_ISSUE,
        S_WAIT,
        S_SEND
    } state_e;

    // State entered after the last address/data byte of a frame.
`ifdef UART_CMD_CHKSUM_EN
    localparam state_e S_FRAME_END = S_CHK;
`else
    localparam state_e S_FRAME_END = S_ISSUE;
`endif

    state_e         state_q;
    logic           req_q;
    logic           mem_type_q;
    logic           rw_q;
    logic [8:0]     addr_q;
    logic [31:0]    wr_data_q;
    logic [1:0]     data_cnt_q;
    logic [TW-1:0]  wait_cnt_q;
    logic [47:0]    tx_buf_q;
    logic [2:0]     tx_left_q;
    logic           tx_valid_q;

    // Only the memory selected by the header can complete a read.
    logic           sel_ready;
    logic [41:0]    sel_data;
    assign sel_ready = mem_type_q ? mem.imem_resp_ready : mem.dmem_resp_ready;
    assign sel_data  = mem_type_q ? mem.imem_resp_data  : mem.dmem_resp_data;

`ifdef UART_CMD_CHKSUM_EN
    logic [7:0] chk_q;

    // Running XOR of header, address and data bytes of the current frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_q <= '0;
        end else if (rx_valid) begin
            if (state_q == S_HDR) begin
                chk_q <= rx_byte;
            end else if (state_q == S_ADDR || state_q == S_DATA) begin
                chk_q <= chk_q ^ rx_byte;
            end
        end
    end
`endif

    // Command FSM with registered bus and UART outputs.
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_HDR;
            req_q      <= 1'b0;
            mem_type_q <= 1'b0;
            rw_q       <= 1'b0;
            addr_q     <= '0;
            wr_data_q  <= '0;
            data_cnt_q <= '0;
            wait_cnt_q <= '0;
            tx_buf_q   <= '0;
            tx_left_q  <= '0;
            tx_valid_q <= 1'b0;
        end else begin
            // The request is a single-cycle pulse: it only survives the cycle
            // in which it was set on entry to S_ISSUE.
            req_q <= 1'b0;
            case (state_q)
                S_HDR: if (rx_valid) begin
                    rw_q       <= rx_byte[7];
                    mem_type_q <= rx_byte[6];
                    addr_q[8]  <= rx_byte[0];
                    state_q    <= S_ADDR;
                end
                S_ADDR: if (rx_valid) begin
                    addr_q[7:0] <= rx_byte;
                    data_cnt_q  <= '0;
                    if (rw_q) begin
                        state_q <= S_DATA;
                    end else begin
                        state_q <= S_FRAME_END;
                        req_q   <= !cpu_enable && (S_FRAME_END == S_ISSUE);
                    end
                end
                S_DATA: if (rx_valid) begin
                    wr_data_q  <= {wr_data_q[23:0], rx_byte};
                    data_cnt_q <= data_cnt_q + 2'd1;
                    if (data_cnt_q == 2'd3) begin
                        state_q <= S_FRAME_END;
                        req_q   <= !cpu_enable && (S_FRAME_END == S_ISSUE);
                    end
                end
`ifdef UART_CMD_CHKSUM_EN
                S_CHK: if (rx_valid) begin
                    if (rx_byte == chk_q) begin
                        state_q <= S_ISSUE;
                        req_q   <= !cpu_enable;
                    end else begin
                        tx_buf_q   <= {NAK_BYTE, 40'd0};
                        tx_left_q  <= 3'd1;
                        tx_valid_q <= 1'b1;
                        state_q    <= S_SEND;
                    end
                end
`endif
                S_ISSUE: begin
                    // req_q low here means the CPU was running: nothing was issued.
                    if (!req_q) begin
                        tx_buf_q   <= {NAK_BYTE, 40'd0};
                        tx_left_q  <= 3'd1;
                        tx_valid_q <= 1'b1;
                        state_q    <= S_SEND;
                    end else if (rw_q) begin
                        tx_buf_q   <= {ACK_BYTE, 40'd0};
                        tx_left_q  <= 3'd1;
                        tx_valid_q <= 1'b1;
                        state_q    <= S_SEND;
                    end else begin
                        wait_cnt_q <= '0;
                        state_q    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (sel_ready) begin
                        tx_buf_q   <= {6'd0, sel_data};
                        tx_left_q  <= 3'd6;
                        tx_valid_q <= 1'b1;
                        state_q    <= S_SEND;
                    end else if (wait_cnt_q == TW'(RESP_TIMEOUT - 1)) begin
                        tx_buf_q   <= {NAK_BYTE, 40'd0};
                        tx_left_q  <= 3'd1;
                        tx_valid_q <= 1'b1;
                        state_q    <= S_SEND;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + TW'(1);
                    end
                end
                S_SEND: if (tx_ready) begin
                    if (tx_left_q == 3'd1) begin
                        tx_buf_q   <= '0;
                        tx_left_q  <= '0;
                        tx_valid_q <= 1'b0;
                        state_q    <= S_HDR;
                    end else begin
                        tx_buf_q  <= {tx_buf_q[39:0], 8'd0};
                        tx_left_q <= tx_left_q - 3'd1;
                    end
                end
                default: state_q <= S_HDR;
            endcase
        end
    end

    assign mem.write_mem_req   = req_q;
    assign mem.target_mem_type = mem_type_q;
    assign mem.target_addr     = addr_q;
    assign mem.rw_flag         = rw_q;
    assign mem.wr_data         = wr_data_q;
    assign tx_byte             = tx_buf_q[47:40];
    assign tx_valid            = tx_valid_q;
    assign busy                = (state_q != S_HDR);
endmodule

// File: tb/tb_uart_mem_cmd_ctrl.sv
// Self-checking bench for uart_mem_cmd_ctrl. A frame-level model turns each
// command into the expected memory request, reply bytes and reply latency;
// one compare process checks every request pulse and every UART handshake.
module tb_uart_mem_cmd_ctrl;
    localparam int         RESP_TIMEOUT = 64;
    localparam logic [7:0] ACK = 8'hA5;
    localparam logic [7:0] NAK = 8'hEE;
`ifdef UART_CMD_CHKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    typedef struct {
        logic        ty;
        logic [8:0]  addr;
        logic        rw;
        logic [31:0] wdata;
    } req_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       cpu_enable;
    logic [7:0] tx_byte;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;

    uart_mem_cmd_ctrl_if mif ();

    uart_mem_cmd_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_byte    (rx_byte),
        .rx_valid   (rx_valid),
        .cpu_enable (cpu_enable),
        .mem        (mif),
        .tx_byte    (tx_byte),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_req_cyc = 0;
    int hs_count = 0;
    int stall_at  = -1;
    int stall_len = 0;
    int resp_delay  = 0;
    int other_delay = 0;
    logic [31:0] resp_word = '0;

    req_t       exp_req[$];
    logic [7:0] exp_tx[$];
    int         exp_lat[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reply for a completed read: {6'b0, 1'b1, addr, data}, sent MSB byte first.
    function automatic logic [47:0] read_reply(input logic [8:0] addr, input logic [31:0] data);
        return {6'd0, 1'b1, addr, data};
    endfunction

    // Memory model: answers reads on the selected memory after resp_delay
    // cycles (0 = never) and pulses the other memory after other_delay cycles.
    initial begin
        logic ty;
        logic [8:0] a;
        mif.imem_resp_ready = 1'b0;
        mif.dmem_resp_ready = 1'b0;
        mif.imem_resp_data  = '0;
        mif.dmem_resp_data  = '0;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n && mif.write_mem_req && !mif.rw_flag) begin
                ty = mif.target_mem_type;
                a  = mif.target_addr;
                for (int k = 1; k <= 2 * RESP_TIMEOUT; k++) begin
                    @(negedge clk);
                    mif.imem_resp_ready = 1'b0;
                    mif.dmem_resp_ready = 1'b0;
                    if (k == resp_delay) begin
                        if (ty) begin
                            mif.imem_resp_data  = {1'b1, a, resp_word};
                            mif.imem_resp_ready = 1'b1;
                        end else begin
                            mif.dmem_resp_data  = {1'b1, a, resp_word};
                            mif.dmem_resp_ready = 1'b1;
                        end
                    end
                    if (k == other_delay) begin
                        if (ty) begin
                            mif.dmem_resp_data  = {1'b1, a, 32'hBAD0BAD0};
                            mif.dmem_resp_ready = 1'b1;
                        end else begin
                            mif.imem_resp_data  = {1'b1, a, 32'hBAD0BAD0};
                            mif.imem_resp_ready = 1'b1;
                        end
                    end
                    if (k > resp_delay && k > other_delay) break;
                end
            end
        end
    end

    // Transmitter model: stalls tx_ready for stall_len cycles once
    // stall_at handshakes have completed.
    initial begin
        int stall_cnt = 0;
        tx_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (hs_count == stall_at && stall_cnt < stall_len) begin
                tx_ready = 1'b0;
                stall_cnt++;
            end else begin
                tx_ready = 1'b1;
                if (hs_count != stall_at) stall_cnt = 0;
            end
        end
    end

    // Compare process: request fields, reply latency, hold-while-stalled, reply bytes.
    req_t       cmp_e;
    int         cmp_off;
    logic       prev_valid = 1'b0;
    logic       prev_ready = 1'b0;
    logic [7:0] prev_byte  = '0;
    always begin
        @(negedge clk);
        #1;
        if (!rst_n) begin
            prev_valid = 1'b0;
            prev_ready = 1'b0;
        end else begin
            if (mif.write_mem_req) begin
                check("req_expected", exp_req.size() != 0, 1);
                if (exp_req.size() != 0) begin
                    cmp_e = exp_req.pop_front();
                    check("req_type", mif.target_mem_type, cmp_e.ty);
                    check("req_addr", mif.target_addr, cmp_e.addr);
                    check("req_rw", mif.rw_flag, cmp_e.rw);
                    if (cmp_e.rw) check("req_wdata", mif.wr_data, cmp_e.wdata);
                end
                last_req_cyc = cyc;
            end
            if (tx_valid && !prev_valid && exp_lat.size() != 0) begin
                cmp_off = exp_lat.pop_front();
                if (cmp_off >= 0) check("reply_latency", cyc - last_req_cyc, cmp_off);
            end
            if (prev_valid && !prev_ready) begin
                check("tx_hold_valid", tx_valid, 1);
                check("tx_hold_byte", tx_byte, prev_byte);
            end
            if (tx_valid && tx_ready) begin
                check("tx_expected", exp_tx.size() != 0, 1);
                if (exp_tx.size() != 0) check("tx_byte", tx_byte, exp_tx.pop_front());
                hs_count++;
            end
            prev_valid = tx_valid;
            prev_ready = tx_ready;
            prev_byte  = tx_byte;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_byte  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    // Frame-level model plus stimulus: records what the command must produce, then sends it.
    task automatic run_cmd(input logic [7:0] f [6], input int n, input logic cpu_en,
                           input bit chk_bad, input int rdly, input int odly,
                           input logic [31:0] rword);
        logic [7:0]  x;
        logic [47:0] r;
        req_t        q;
        bit          ok;
        q.rw    = f[0][7];
        q.ty    = f[0][6];
        q.addr  = {f[0][0], f[1]};
        q.wdata = q.rw ? {f[2], f[3], f[4], f[5]} : 32'h0;
        x = '0;
        for (int i = 0; i < n; i++) x ^= f[i];
        ok = !(CHK_EN && chk_bad);
        cpu_enable  = cpu_en;
        resp_delay  = rdly;
        other_delay = odly;
        resp_word   = rword;
        if (!ok || cpu_en) begin
            exp_tx.push_back(NAK);
            exp_lat.push_back(-1);
        end else begin
            exp_req.push_back(q);
            if (q.rw) begin
                exp_tx.push_back(ACK);
                exp_lat.push_back(1);
            end else if (rdly >= 1 && rdly <= RESP_TIMEOUT) begin
                r = read_reply(q.addr, rword);
                for (int i = 0; i < 6; i++) exp_tx.push_back(r[47 - 8 * i -: 8]);
                exp_lat.push_back(rdly + 1);
            end else begin
                exp_tx.push_back(NAK);
                exp_lat.push_back(RESP_TIMEOUT + 1);
            end
        end
        for (int i = 0; i < n; i++) send_byte(f[i]);
        if (CHK_EN) send_byte(x ^ {7'd0, chk_bad});
    endtask

    task automatic wait_idle(input string name);
        bit done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk);
            #2;
            done = (exp_tx.size() == 0) && !busy;
        end
        check({name, "_done"}, done, 1);
        check({name, "_req_left"}, exp_req.size(), 0);
        exp_tx.delete();
        exp_req.delete();
        exp_lat.delete();
    endtask

    task automatic check_outputs_zero(input string name);
        check({name, "_req"}, mif.write_mem_req, 0);
        check({name, "_addr"}, mif.target_addr, 0);
        check({name, "_type"}, mif.target_mem_type, 0);
        check({name, "_rw"}, mif.rw_flag, 0);
        check({name, "_wdata"}, mif.wr_data, 0);
        check({name, "_tx_valid"}, tx_valid, 0);
        check({name, "_tx_byte"}, tx_byte, 0);
        check({name, "_busy"}, busy, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n      = 1'b0;
        rx_byte    = '0;
        rx_valid   = 1'b0;
        cpu_enable = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_outputs_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Pin the model against hand-computed replies.
        check("model_pin_read", read_reply(9'h101, 32'h0000_0013), 48'h03_01_00_00_00_13);
        check("model_pin_read2", read_reply(9'h010, 32'h1234_5678), 48'h02_10_12_34_56_78);

        // Data-memory write with the CPU halted.
        run_cmd('{8'h80, 8'h05, 8'hDE, 8'hAD, 8'hBE, 8'hEF}, 6, 1'b0, 1'b0, 0, 0, 32'h0);
        wait_idle("write");
        check("write_hold_addr", mif.target_addr, 9'h005);
        check("write_hold_wdata", mif.wr_data, 32'hDEADBEEF);
        check("write_hold_rw", mif.rw_flag, 1);
        check("write_hold_type", mif.target_mem_type, 0);

        // Instruction-memory read, response on the earliest legal cycle (header 0x41 carries addr[8]=1).
        run_cmd('{8'h41, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00}, 2, 1'b0, 1'b0, 1, 0, 32'h0000_0013);
        wait_idle("imem_read");

        // Data-memory read with a slower response.
        run_cmd('{8'h00, 8'h1F, 8'h00, 8'h00, 8'h00, 8'h00}, 2, 1'b0, 1'b0, 5, 0, 32'hCAFE_F00D);
        wait_idle("dmem_read");

        // Timeout: the instruction memory strobes, but a data read is waiting.
        run_cmd('{8'h00, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00}, 2, 1'b0, 1'b0, 0, 3, 32'h1111_2222);
        wait_idle("timeout");

        // Strobe on the very last cycle of the wait window still completes.
        run_cmd('{8'h40, 8'h33, 8'h00, 8'h00, 8'h00, 8'h00}, 2, 1'b0, 1'b0, RESP_TIMEOUT, 0, 32'h0BAD_F00D);
        wait_idle("late_read");

        // CPU running: no request, NAK for both write and read.
        run_cmd('{8'h80, 8'h09, 8'h01, 8'h02, 8'h03, 8'h04}, 6, 1'b1, 1'b0, 0, 0, 32'h0);
        wait_idle("cpu_en_write");
        run_cmd('{8'h40, 8'h09, 8'h00, 8'h00, 8'h00, 8'h00}, 2, 1'b1, 1'b0, 1, 0, 32'h0);
        wait_idle("cpu_en_read");

        // Transmitter stall mid-reply with junk rx bytes dropped during S_SEND.
        stall_at  = hs_count + 2;
        stall_len = 10;
        run_cmd('{8'h40, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00}, 2, 1'b0, 1'b0, 2, 0, 32'h1234_5678);
        for (int i = 0; i < 100 && hs_count < stall_at; i++) @(negedge clk);
        send_byte(8'h80);
        send_byte(8'h40);
        wait_idle("stall_read");
        stall_at = -1;
        run_cmd('{8'h81, 8'hFF, 8'h01, 8'h02, 8'h03, 8'h04}, 6, 1'b0, 1'b0, 0, 0, 32'h0);
        wait_idle("after_junk_write");

        // Reset in the middle of the data bytes aborts the command silently.
        send_byte(8'h80);
        #1;
        check("busy_after_hdr", busy, 1);
        send_byte(8'h05);
        send_byte(8'hDE);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_outputs_zero("mid_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_cmd('{8'h80, 8'h06, 8'h55, 8'h66, 8'h77, 8'h88}, 6, 1'b0, 1'b0, 0, 0, 32'h0);
        wait_idle("post_reset_write");

`ifdef UART_CMD_CHKSUM_EN
        // Good checksum issues the read; bad checksum NAKs with no request.
        run_cmd('{8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00}, 2, 1'b0, 1'b0, 1, 0, 32'hA5A5_0001);
        wait_idle("chk_good");
        run_cmd('{8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00}, 2, 1'b0, 1'b1, 1, 0, 32'hA5A5_0001);
        wait_idle("chk_bad");
`endif

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
